// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE 754 min/max scan block: format constants,
// controller state encoding and a format-generic NaN test.
package fp_pkg;

    // Default binary32 field constants.
    localparam logic [7:0]  MAX_EXP    = 8'hFF;
    localparam logic [22:0] ZERO_MANT  = 23'h0;
    localparam logic [31:0] QNAN_CANON = {1'b0, MAX_EXP, 1'b1, ZERO_MANT[21:0]};

    // Controller states; the encoding is visible on the debug output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // NaN = exponent all ones and mantissa non-zero. Fields are passed
    // zero-extended so one function serves any format up to 16/64 bits.
    function automatic logic is_nan(input logic [15:0] exp_f,
                                    input logic [15:0] exp_ones,
                                    input logic [63:0] mant_f);
        return (exp_f == exp_ones) && (mant_f != 64'd0);
    endfunction

endpackage

// File: rtl/fp_minmax_scan_ieee_comp.sv
// Combinational IEEE 754 comparator: reports a>b, a<b, a==b or unordered.
// +0 and -0 compare equal; infinities order normally; any NaN is unordered.
module ieee_comp
    import fp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             unord
);

    localparam logic [15:0] EXP_ONES = 16'((1 << EXP_WIDTH) - 1);

    logic w_a_nan;
    logic w_b_nan;
    logic w_a_zero;
    logic w_b_zero;
    logic w_mag_gt;

    assign w_a_nan  = is_nan(16'(a[WIDTH-2 -: EXP_WIDTH]), EXP_ONES, 64'(a[MANT_WIDTH-1:0]));
    assign w_b_nan  = is_nan(16'(b[WIDTH-2 -: EXP_WIDTH]), EXP_ONES, 64'(b[MANT_WIDTH-1:0]));
    assign w_a_zero = (a[WIDTH-2:0] == '0);
    assign w_b_zero = (b[WIDTH-2:0] == '0);
    assign w_mag_gt = (a[WIDTH-2:0] > b[WIDTH-2:0]);

    // Sign-magnitude ordering with the zero and NaN special cases first.
    always_comb begin
        gt    = 1'b0;
        lt    = 1'b0;
        eq    = 1'b0;
        unord = 1'b0;
        if (w_a_nan || w_b_nan) begin
            unord = 1'b1;
        end else if ((w_a_zero && w_b_zero) || (a == b)) begin
            eq = 1'b1;
        end else if (a[WIDTH-1] != b[WIDTH-1]) begin
            gt = ~a[WIDTH-1];
            lt = a[WIDTH-1];
        end else if (!a[WIDTH-1]) begin
            gt = w_mag_gt;
            lt = ~w_mag_gt;
        end else begin
            gt = ~w_mag_gt;
            lt = w_mag_gt;
        end
    end

endmodule

// File: rtl/fp_minmax_scan.sv
// Streaming argmax/argmin over a packet of IEEE 754 values. One element per
// cycle in, one result beat per packet out, one shared comparator.
//
// Handshake: a beat transfers on a rising edge where valid && ready. The
// producer holds data/last stable while valid && !ready. out_valid stays high
// with stable outputs until out_ready; in_ready is low for that whole time,
// so a new packet starts no earlier than the cycle after the result leaves.
module fp_minmax_scan
    import fp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_nan_seen,
    output logic             out_all_nan,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);

    localparam logic [15:0]      EXP_ONES = 16'((1 << EXP_WIDTH) - 1);
    localparam logic [IDX_W-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] QNAN     = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_mode;
    logic [IDX_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_best_val;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_have_val;
    logic             r_nan_seen;
    logic             r_ovf;

    logic             w_accept;
    logic             w_first;
    logic             w_mode_eff;
    logic             w_have_eff;
    logic [IDX_W-1:0] w_cnt_before;
    logic             w_in_nan;
    logic             w_update;
    logic             w_done;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic             w_unord;

    ieee_comp #(
        .WIDTH      (WIDTH),
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_comp (
        .a     (in_data),
        .b     (r_best_val),
        .gt    (w_gt),
        .lt    (w_lt),
        .eq    (w_eq),
        .unord (w_unord)
    );

    assign in_ready  = (r_state != DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_done    = (r_state == DONE);
    assign dbg_state = r_state;

    // The first beat of a packet sees fresh context, not leftovers in the registers.
    assign w_first      = (r_state == IDLE);
    assign w_mode_eff   = w_first ? mode : r_mode;
    assign w_have_eff   = w_first ? 1'b0 : r_have_val;
    assign w_cnt_before = w_first ? '0 : r_cnt;
    assign w_in_nan     = is_nan(16'(in_data[WIDTH-2 -: EXP_WIDTH]), EXP_ONES,
                                 64'(in_data[MANT_WIDTH-1:0]));
    // Ties (eq) and unordered never replace the current winner.
    assign w_update     = !w_in_nan && (!w_have_eff || (w_mode_eff ? w_lt : w_gt));

    // Result outputs are only driven while the result beat is presented.
    assign out_valid    = w_done;
    assign out_value    = w_done ? (r_have_val ? r_best_val : QNAN) : '0;
    assign out_index    = (w_done && r_have_val) ? r_best_idx : '0;
    assign out_count    = w_done ? r_cnt : '0;
    assign out_nan_seen = w_done && r_nan_seen;
    assign out_all_nan  = w_done && !r_have_val;
    assign out_ovf      = w_done && r_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept until last, then hold the result until taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Per-element accumulation: count, flags, and the running winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_cnt      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_have_val <= 1'b0;
            r_nan_seen <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                r_mode     <= mode;
                r_cnt      <= IDX_W'(1);
                r_nan_seen <= w_in_nan;
                r_ovf      <= 1'b0;
                r_have_val <= !w_in_nan;
            end else begin
                if (r_cnt == CNT_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + IDX_W'(1);
                end
                if (w_in_nan) begin
                    r_nan_seen <= 1'b1;
                end
                if (!w_in_nan) begin
                    r_have_val <= 1'b1;
                end
            end
            // Pre-increment count is the index; it pins at CNT_MAX once saturated.
            if (w_update) begin
                r_best_val <= in_data;
                r_best_idx <= w_cnt_before;
            end
        end
    end

endmodule

// File: doc/fp_minmax_scan.md
Name: fp_minmax_scan

Overview:
- Streaming reduction controller. Finds the maximum or minimum of a packet of IEEE 754 values, and its index, using one shared combinational comparator instance (ieee_comp).
- Accepts one element per cycle on a valid/ready input stream, then presents one result beat per packet on a valid/ready output.
- Sits between the operand buffers and the ALU754 result path; used for argmax/argmin jobs.

Parameters:
- WIDTH, 32, total float width
- EXP_WIDTH, 8, exponent width
- MANT_WIDTH, 23, mantissa width
- IDX_W, 8, element index/count width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = max, 1 = min; sampled on the first accepted beat of a packet
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  WIDTH  element value
- in_last  in  1  final element of packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_value  out  WIDTH  winning value
- out_index  out  IDX_W  zero-based index of the winner
- out_count  out  IDX_W  number of elements accepted, saturating
- out_nan_seen  out  1  at least one NaN in packet
- out_all_nan  out  1  every element was NaN
- out_ovf  out  1  packet exceeded 2^IDX_W-1 elements

Behaviour:
- Reset: the async assert forces state IDLE. All outputs clear to 0, including out_valid and out_value; in_ready is 1. Reset mid-packet discards the partial result.
- States: IDLE, ACCUM, DONE. in_ready = (state != DONE).
- IDLE + accept: latch mode_r = mode and cnt = 1, then process the element. Go to DONE if in_last, else ACCUM.
- ACCUM + accept: process the element and increment cnt, saturating at 2^IDX_W-1. Set ovf when an increment is attempted at saturation. in_last moves the state to DONE.
- DONE: out_valid = 1 and all outputs are held stable. On out_ready, go to IDLE.
  - A new packet beat cannot be accepted in the same cycle as out_ready. This guarantees one bubble between packets.
- Element processing:
  - Compare in_data (A) against best_val (B).
  - NaN = exponent all ones and mantissa non-zero. A NaN element is skipped for the winner but sets nan_seen.
  - The first non-NaN element of the packet loads best_val and best_idx = cnt_before, and sets have_val.
  - Afterwards, update when (mode_r == 0 and gt) or (mode_r == 1 and lt).
  - eq never updates, so ties keep the earliest index. +0 and -0 compare equal, so the first one wins.
  - Infinities compare normally.
- Index: best_idx takes the pre-increment count. Once the count has saturated, an update sets the index to 2^IDX_W-1.
- Result:
  - out_value = best_val, or canonical qNaN (sign 0, exponent all ones, mantissa MSB 1) if !have_val.
  - out_all_nan = !have_val.
  - out_index = best_idx, or 0 if all NaN.
- Latency: the result is valid in the cycle after the in_last beat is accepted. Throughput is one element per cycle while in_ready.
- in_valid without in_ready holds no state. Input stalls in ACCUM are unlimited.
- The comparator path is combinational within one cycle, with registered outputs only.

Decomposition:
- Shared package fp_pkg:
  - localparams MAX_EXP, ZERO_MANT, QNAN_CANON
  - the state enum
  - function is_nan
- Sub-module: ieee_comp, one instance, comb compare of in_data vs best_val.
- All control lives in fp_minmax_scan. A separate FSM module is unnecessary.

Test Plan:
- Max, data 3F800000, 40000000 (last), mode 0 -> out_value 40000000, index 1, count 2, 1 cycle after last.
- Min, data 40000000, C0400000, 3F800000 (last), mode 1 -> out_value C0400000, index 1, count 3.
- Ties/zeros, max, data 80000000, 00000000 (last) -> out_value 80000000, index 0, since eq keeps the first.
- NaN handling:
  - Max, data 7FC00001, 7F800000 (last) -> out_value 7F800000, index 1, nan_seen 1, all_nan 0.
  - All NaN (7FC00001 x2) -> out_value 7FC00000, index 0, all_nan 1.
- Backpressure/reset:
  - out_ready low for 5 cycles -> outputs stable, in_ready 0.
  - rst pulsed mid-ACCUM -> out_valid 0, state IDLE; the next packet's result is unaffected by the old data.
- Overflow, IDX_W=2, 5 elements ascending 1.0..5.0 -> count 3, ovf 1, out_value 40A00000, index 3.
